uart_rx_fifo: RTL and testbench

- UART receiver for the SoC serial-input path: 8N1 framing, mid-bit sampling, receive FIFO.
- Sits between the board-level Uart_Rx pin and the SoC's ser_rx consumer logic.
- Decodes the framing that the SoC's ser_tx transmitter produces.
- Buffers received bytes and hands them to the core over a valid/ready handshake.
- Reports framing errors and overruns as single-cycle pulses.

---
 rtl/uart_rx_fifo.sv | 184 ++++++++++++++++++
 tb/tb_uart_rx_fifo.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver with mid-bit sampling, feeding a small circular receive FIFO
// that is drained over a valid/ready handshake.
//
// state     | meaning
// ----------+---------------------------------------------------------------
// IDLE      | line idle, waiting for a falling edge on the synced input
// START     | counting to the middle of the start bit to confirm it
// DATA      | sampling eight data bits LSB-first, one per bit period
// STOP      | sampling the stop bit; high pushes the byte, low is a framing error
// WAIT_HIGH | after a framing error, waiting for the line to return high
module uart_rx_fifo #(
   parameter int CLKS_PER_BIT = 434,
   parameter int DEPTH        = 8
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     ser_rx,
   output logic [7:0]               rx_data,
   output logic                     rx_valid,
   input  logic                     rx_ready,
   output logic [$clog2(DEPTH):0]   rx_count,
   output logic                     frame_err,
   output logic                     rx_overrun
);

   localparam int CNT_W = $clog2(CLKS_PER_BIT);
   localparam int PW    = $clog2(DEPTH);
   localparam int CW    = PW + 1;

   localparam logic [CNT_W-1:0] HALF_LD = CNT_W'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CNT_W-1:0] FULL_LD = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0]    FULL_CNT = CW'(DEPTH);

   localparam logic [2:0] ST_IDLE      = 3'd0;
   localparam logic [2:0] ST_START     = 3'd1;
   localparam logic [2:0] ST_DATA      = 3'd2;
   localparam logic [2:0] ST_STOP      = 3'd3;
   localparam logic [2:0] ST_WAIT_HIGH = 3'd4;

   logic             sync1_q, sync2_q;
   logic             rxs;
   logic [2:0]       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [2:0]       bit_q, bit_d;
   logic [7:0]       shreg_q, shreg_d;
   logic             ferr_q, ferr_d;
   logic             ovr_q, ovr_d;
   logic             push;
   logic             cnt_zero;

   logic [7:0]       mem_q [DEPTH];
   logic [PW-1:0]    wr_q, wr_d;
   logic [PW-1:0]    rd_q, rd_d;
   logic [CW-1:0]    count_q, count_d;
   logic             pop;
   logic             full;
   logic             wr_en;

   // Two-flop synchronizer; reset to the idle-high line level.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync1_q <= 1'b1;
         sync2_q <= 1'b1;
      end else begin
         sync1_q <= ser_rx;
         sync2_q <= sync1_q;
      end
   end

   assign rxs      = sync2_q;
   assign cnt_zero = (cnt_q == '0);

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      bit_d   = bit_q;
      shreg_d = shreg_q;
      push    = 1'b0;
      ferr_d  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (!rxs) begin
               cnt_d   = HALF_LD;
               state_d = ST_START;
            end
         end
         ST_START: begin
            if (!cnt_zero) begin
               cnt_d = cnt_q - 1'b1;
            end else if (rxs) begin
               state_d = ST_IDLE;
            end else begin
               cnt_d   = FULL_LD;
               bit_d   = 3'd0;
               state_d = ST_DATA;
            end
         end
         ST_DATA: begin
            if (!cnt_zero) begin
               cnt_d = cnt_q - 1'b1;
            end else begin
               shreg_d = {rxs, shreg_q[7:1]};
               cnt_d   = FULL_LD;
               bit_d   = 3'(bit_q + 3'd1);
               if (bit_q == 3'd7) state_d = ST_STOP;
            end
         end
         ST_STOP: begin
            if (!cnt_zero) begin
               cnt_d = cnt_q - 1'b1;
            end else if (rxs) begin
               push    = 1'b1;
               state_d = ST_IDLE;
            end else begin
               ferr_d  = 1'b1;
               state_d = ST_WAIT_HIGH;
            end
         end
         ST_WAIT_HIGH: begin
            if (rxs) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // A pop in the same cycle frees the head slot, so a push into a full FIFO is still taken.
   assign pop   = rx_valid & rx_ready;
   assign full  = (count_q == FULL_CNT);
   assign wr_en = push & (~full | pop);
   assign ovr_d = push & full & ~pop;

   always_comb begin
      wr_d    = wr_q;
      rd_d    = rd_q;
      count_d = count_q;
      if (wr_en) wr_d = wr_q + 1'b1;
      if (pop)   rd_d = rd_q + 1'b1;
      case ({wr_en, pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         bit_q   <= '0;
         shreg_q <= '0;
         ferr_q  <= 1'b0;
         ovr_q   <= 1'b0;
         wr_q    <= '0;
         rd_q    <= '0;
         count_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         bit_q   <= bit_d;
         shreg_q <= shreg_d;
         ferr_q  <= ferr_d;
         ovr_q   <= ovr_d;
         wr_q    <= wr_d;
         rd_q    <= rd_d;
         count_q <= count_d;
      end
   end

   // Storage is cleared on reset so the head byte reads as zero while empty.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      end else if (wr_en) begin
         mem_q[wr_q] <= shreg_q;
      end
   end

   assign rx_data    = mem_q[rd_q];
   assign rx_valid   = (count_q != '0);
   assign rx_count   = count_q;
   assign frame_err  = ferr_q;
   assign rx_overrun = ovr_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo at 16 clocks per bit and a 4-entry FIFO;
// each scenario task drives serial frames and checks the handshake and pulses.
module tb_uart_rx_fifo;

   localparam int CPB = 16;
   localparam int DEP = 4;

   logic       clk = 1'b0;
   logic       reset;
   logic       ser_rx;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       rx_ready;
   logic [2:0] rx_count;
   logic       frame_err;
   logic       rx_overrun;

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;
   int fe_cnt  = 0;
   int ov_cnt  = 0;
   int last_rise = -1;
   int t_start   = 0;
   logic prev_v  = 1'b0;

   uart_rx_fifo #(.CLKS_PER_BIT(CPB), .DEPTH(DEP)) dut (
      .clk        (clk),
      .reset      (reset),
      .ser_rx     (ser_rx),
      .rx_data    (rx_data),
      .rx_valid   (rx_valid),
      .rx_ready   (rx_ready),
      .rx_count   (rx_count),
      .frame_err  (frame_err),
      .rx_overrun (rx_overrun)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (frame_err)  fe_cnt = fe_cnt + 1;
      if (rx_overrun) ov_cnt = ov_cnt + 1;
      if (rx_valid && !prev_v) last_rise = cyc;
      prev_v = rx_valid;
   end

   // Called at a negedge; drives one frame and optionally pops in the push cycle.
   task automatic send_frame(input logic [7:0] b, input logic stop_v, input bit pop_at_push);
      t_start = cyc;
      ser_rx = 1'b0;
      repeat (CPB) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         ser_rx = b[i];
         repeat (CPB) @(negedge clk);
      end
      ser_rx = stop_v;
      for (int i = 0; i < CPB; i++) begin
         rx_ready = (pop_at_push && i == 10);
         @(negedge clk);
      end
      rx_ready = 1'b0;
      ser_rx   = 1'b1;
   endtask

   task automatic test_reset();
      reset = 1'b1; ser_rx = 1'b1; rx_ready = 1'b0;
      repeat (3) @(negedge clk);
      n_tests++; if (rx_valid !== 1'b0) begin $display("FAIL reset_valid got %b exp 0", rx_valid); n_fail++; end
      n_tests++; if (rx_data !== 8'h00) begin $display("FAIL reset_data got %h exp 00", rx_data); n_fail++; end
      n_tests++; if (rx_count !== 3'd0) begin $display("FAIL reset_count got %0d exp 0", rx_count); n_fail++; end
      n_tests++; if (frame_err !== 1'b0 || rx_overrun !== 1'b0) begin
         $display("FAIL reset_pulses got fe=%b ov=%b exp 0 0", frame_err, rx_overrun); n_fail++; end
      reset = 1'b0;
      repeat (5) @(negedge clk);
   endtask

   task automatic test_basic();
      int fe0, ov0, lat;
      fe0 = fe_cnt; ov0 = ov_cnt;
      send_frame(8'hA5, 1'b1, 1'b0);
      lat = last_rise - t_start;
      n_tests++; if (lat < 152 || lat > 158) begin $display("FAIL basic_latency got %0d exp 152..158", lat); n_fail++; end
      n_tests++; if (rx_valid !== 1'b1) begin $display("FAIL basic_valid got %b exp 1", rx_valid); n_fail++; end
      n_tests++; if (rx_data !== 8'hA5) begin $display("FAIL basic_data got %h exp a5", rx_data); n_fail++; end
      n_tests++; if (rx_count !== 3'd1) begin $display("FAIL basic_count got %0d exp 1", rx_count); n_fail++; end
      n_tests++; if (fe_cnt != fe0 || ov_cnt != ov0) begin
         $display("FAIL basic_pulses got fe=%0d ov=%0d exp 0 0", fe_cnt - fe0, ov_cnt - ov0); n_fail++; end
      rx_ready = 1'b1;
      @(negedge clk);
      rx_ready = 1'b0;
      n_tests++; if (rx_valid !== 1'b0) begin $display("FAIL basic_pop_valid got %b exp 0", rx_valid); n_fail++; end
      n_tests++; if (rx_count !== 3'd0) begin $display("FAIL basic_pop_count got %0d exp 0", rx_count); n_fail++; end
      rx_ready = 1'b1;
      repeat (2) @(negedge clk);
      rx_ready = 1'b0;
      n_tests++; if (rx_count !== 3'd0) begin $display("FAIL empty_pop_count got %0d exp 0", rx_count); n_fail++; end
   endtask

   task automatic test_glitch();
      int fe0;
      fe0 = fe_cnt;
      ser_rx = 1'b0;
      repeat (4) @(negedge clk);
      ser_rx = 1'b1;
      repeat (40) @(negedge clk);
      n_tests++; if (rx_count !== 3'd0) begin $display("FAIL glitch_count got %0d exp 0", rx_count); n_fail++; end
      n_tests++; if (fe_cnt != fe0) begin $display("FAIL glitch_ferr got %0d exp 0", fe_cnt - fe0); n_fail++; end
      send_frame(8'h3C, 1'b1, 1'b0);
      n_tests++; if (rx_count !== 3'd1 || rx_data !== 8'h3C) begin
         $display("FAIL glitch_next got cnt=%0d data=%h exp 1 3c", rx_count, rx_data); n_fail++; end
      rx_ready = 1'b1; @(negedge clk); rx_ready = 1'b0;
   endtask

   task automatic test_frame_err();
      int fe0;
      fe0 = fe_cnt;
      send_frame(8'h55, 1'b0, 1'b0);
      ser_rx = 1'b0;
      repeat (64) @(negedge clk);
      ser_rx = 1'b1;
      repeat (32) @(negedge clk);
      n_tests++; if (fe_cnt - fe0 != 1) begin $display("FAIL ferr_pulses got %0d exp 1", fe_cnt - fe0); n_fail++; end
      n_tests++; if (rx_count !== 3'd0) begin $display("FAIL ferr_count got %0d exp 0", rx_count); n_fail++; end
      send_frame(8'h12, 1'b1, 1'b0);
      n_tests++; if (rx_count !== 3'd1 || rx_data !== 8'h12) begin
         $display("FAIL ferr_next got cnt=%0d data=%h exp 1 12", rx_count, rx_data); n_fail++; end
      n_tests++; if (fe_cnt - fe0 != 1) begin $display("FAIL ferr_after got %0d exp 1", fe_cnt - fe0); n_fail++; end
      rx_ready = 1'b1; @(negedge clk); rx_ready = 1'b0;
   endtask

   task automatic test_overrun();
      int ov0, fe0;
      logic [7:0] exp_b;
      ov0 = ov_cnt; fe0 = fe_cnt;
      for (int k = 1; k <= 5; k++) send_frame(8'(k), 1'b1, 1'b0);
      n_tests++; if (rx_count !== 3'd4) begin $display("FAIL ovr_count got %0d exp 4", rx_count); n_fail++; end
      n_tests++; if (ov_cnt - ov0 != 1) begin $display("FAIL ovr_pulses got %0d exp 1", ov_cnt - ov0); n_fail++; end
      n_tests++; if (fe_cnt != fe0) begin $display("FAIL ovr_ferr got %0d exp 0", fe_cnt - fe0); n_fail++; end
      for (int k = 1; k <= 4; k++) begin
         exp_b = 8'(k);
         n_tests++; if (rx_valid !== 1'b1 || rx_data !== exp_b) begin
            $display("FAIL ovr_drain%0d got v=%b data=%h exp 1 %h", k, rx_valid, rx_data, exp_b); n_fail++; end
         rx_ready = 1'b1; @(negedge clk);
      end
      rx_ready = 1'b0;
      n_tests++; if (rx_count !== 3'd0) begin $display("FAIL ovr_empty got %0d exp 0", rx_count); n_fail++; end
   endtask

   task automatic test_full_pop();
      int ov0;
      logic [7:0] exp_b;
      for (int k = 1; k <= 4; k++) send_frame(8'(k), 1'b1, 1'b0);
      n_tests++; if (rx_count !== 3'd4) begin $display("FAIL fullpop_fill got %0d exp 4", rx_count); n_fail++; end
      ov0 = ov_cnt;
      send_frame(8'h05, 1'b1, 1'b1);
      n_tests++; if (ov_cnt != ov0) begin $display("FAIL fullpop_ovr got %0d exp 0", ov_cnt - ov0); n_fail++; end
      n_tests++; if (rx_count !== 3'd4) begin $display("FAIL fullpop_count got %0d exp 4", rx_count); n_fail++; end
      for (int k = 2; k <= 5; k++) begin
         exp_b = 8'(k);
         n_tests++; if (rx_valid !== 1'b1 || rx_data !== exp_b) begin
            $display("FAIL fullpop_drain%0d got v=%b data=%h exp 1 %h", k, rx_valid, rx_data, exp_b); n_fail++; end
         rx_ready = 1'b1; @(negedge clk);
      end
      rx_ready = 1'b0;
      n_tests++; if (rx_count !== 3'd0) begin $display("FAIL fullpop_empty got %0d exp 0", rx_count); n_fail++; end
   endtask

   task automatic test_reset_mid();
      logic [7:0] b;
      b = 8'hC3;
      send_frame(8'h11, 1'b1, 1'b0);
      send_frame(8'h22, 1'b1, 1'b0);
      n_tests++; if (rx_count !== 3'd2) begin $display("FAIL rstmid_fill got %0d exp 2", rx_count); n_fail++; end
      ser_rx = 1'b0;
      repeat (CPB) @(negedge clk);
      for (int i = 0; i < 3; i++) begin
         ser_rx = b[i];
         repeat (CPB) @(negedge clk);
      end
      ser_rx = b[3];
      repeat (8) @(negedge clk);
      reset = 1'b1;
      #1;
      n_tests++; if (rx_valid !== 1'b0 || rx_count !== 3'd0) begin
         $display("FAIL rstmid_fifo got v=%b cnt=%0d exp 0 0", rx_valid, rx_count); n_fail++; end
      n_tests++; if (rx_data !== 8'h00 || frame_err !== 1'b0 || rx_overrun !== 1'b0) begin
         $display("FAIL rstmid_out got data=%h fe=%b ov=%b exp 00 0 0", rx_data, frame_err, rx_overrun); n_fail++; end
      ser_rx = 1'b1;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      repeat (40) @(negedge clk);
      send_frame(8'h7E, 1'b1, 1'b0);
      n_tests++; if (rx_count !== 3'd1 || rx_data !== 8'h7E) begin
         $display("FAIL rstmid_next got cnt=%0d data=%h exp 1 7e", rx_count, rx_data); n_fail++; end
      rx_ready = 1'b1; @(negedge clk); rx_ready = 1'b0;
      n_tests++; if (rx_count !== 3'd0) begin $display("FAIL rstmid_empty got %0d exp 0", rx_count); n_fail++; end
   endtask

   initial begin
      reset = 1'b1; ser_rx = 1'b1; rx_ready = 1'b0;
      @(negedge clk);
      test_reset();
      test_basic();
      repeat (20) @(negedge clk);
      test_glitch();
      repeat (20) @(negedge clk);
      test_frame_err();
      repeat (20) @(negedge clk);
      test_overrun();
      repeat (20) @(negedge clk);
      test_full_pop();
      repeat (20) @(negedge clk);
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
